// File: rtl/regfile_bist_pkg.sv
// Shared types and pattern generator for the register-file BIST initiator.
package regfile_bist_pkg;

  localparam int unsigned PAT_W = 64;
  localparam logic [31:0] PAT_SEED_DFLT = 32'hA5A5_A5A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_RD_A,
    ST_WR_B,
    ST_RD_B,
    ST_DONE
  } bist_state_t;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } bist_phase_t;

  // Pattern A is seed ^ address; pattern B is its complement.
  function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] seed,
                                                    input logic [PAT_W-1:0] addr,
                                                    input bist_phase_t phase);
    logic [PAT_W-1:0] a;
    a = seed ^ addr;
    return (phase == PH_B) ? ~a : a;
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Control/status and register-file port bundle between the BIST and its surroundings.
interface regfile_bist_if #(
  parameter int unsigned SELW  = 5,
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SELW-1:0]  fail_addr;
  logic             fail_port;
  logic [SELW-1:0]  rf_wsel;
  logic [WIDTH-1:0] rf_data;
  logic             rf_we;
  logic [SELW-1:0]  rf_r1sel;
  logic [SELW-1:0]  rf_r2sel;
  logic [WIDTH-1:0] rf_reg1;
  logic [WIDTH-1:0] rf_reg2;

  modport master (
    input  start, rf_reg1, rf_reg2,
    output busy, done, pass, fail_addr, fail_port,
           rf_wsel, rf_data, rf_we, rf_r1sel, rf_r2sel
  );

  modport slave (
    output start, rf_reg1, rf_reg2,
    input  busy, done, pass, fail_addr, fail_port,
           rf_wsel, rf_data, rf_we, rf_r1sel, rf_r2sel
  );
endinterface

// File: rtl/bist_addr_gen.sv
// Up/down march address counter; direction is captured on load, tc flags the last address.
module bist_addr_gen #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned SELW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            load_down,
  input  logic [SELW-1:0] load_val,
  input  logic            en,
  output logic [SELW-1:0] cnt,
  output logic [SELW-1:0] cnt_nxt_c,
  output logic            tc_c
);

  localparam logic [SELW-1:0] CNT_MAX = SELW'(NREGS - 1);

  logic [SELW-1:0] cnt_q;
  logic            down_q;

  always_comb begin
    cnt_nxt_c = cnt_q;
    if (load) begin
      cnt_nxt_c = load_val;
    end else if (en) begin
      cnt_nxt_c = down_q ? (cnt_q - SELW'(1)) : (cnt_q + SELW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      down_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt_c;
      if (load) begin
        down_q <= load_down;
      end
    end
  end

  assign cnt  = cnt_q;
  assign tc_c = down_q ? (cnt_q == '0) : (cnt_q == CNT_MAX);

endmodule

// File: rtl/regfile_bist.sv
// March BIST initiator for a 2R/1W register file: WR_A, RD_A, WR_B, RD_B, then pass/fail report.
// Optional REGFILE_BIST_DUALPORT_EN also checks read port 2 one address behind port 1.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned SELW     = 5,
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] PAT_SEED = PAT_SEED_DFLT,
  parameter bit          R0_ZERO  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  regfile_bist_if.master bus
);

  localparam logic [SELW-1:0] ADDR_MAX = SELW'(NREGS - 1);

  bist_state_t state, state_nxt;

  logic            ag_load, ag_load_down, ag_en;
  logic [SELW-1:0] ag_load_val;
  logic [SELW-1:0] cnt, cnt_nxt_c;
  logic            tc_c;

  logic            rd_phase_c, mis1_c, mis2_c, mis_c;
  bist_phase_t     ph_c;
  logic [SELW-1:0] fail_sel_c;

  logic             busy_q, done_q, pass_q, fail_port_q, we_q;
  logic [SELW-1:0]  fail_addr_q, wsel_q, r1sel_q, r2sel_q;
  logic [WIDTH-1:0] data_q;

  logic             busy_nxt, done_nxt, pass_nxt, fail_port_nxt, we_nxt;
  logic [SELW-1:0]  fail_addr_nxt, wsel_nxt, r1sel_nxt, r2sel_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             wr_nxt, rd_nxt;
  bist_phase_t      ph_nxt;

  // Value a healthy register file must return for address a in the given phase.
  function automatic logic [WIDTH-1:0] exp_val(input logic [SELW-1:0] a, input bist_phase_t ph);
    if (R0_ZERO && (a == '0)) begin
      return '0;
    end
    return WIDTH'(bist_pattern(PAT_W'(PAT_SEED), PAT_W'(a), ph));
  endfunction

  bist_addr_gen #(
    .NREGS (NREGS),
    .SELW  (SELW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .load_down (ag_load_down),
    .load_val  (ag_load_val),
    .en        (ag_en),
    .cnt       (cnt),
    .cnt_nxt_c (cnt_nxt_c),
    .tc_c      (tc_c)
  );

  // Read-data compare against the expected pattern for the current address(es).
`ifdef REGFILE_BIST_DUALPORT_EN
  logic            first_rd_c;
  logic [SELW-1:0] cnt_m1_c;

  always_comb begin
    rd_phase_c = (state == ST_RD_A) || (state == ST_RD_B);
    ph_c       = ((state == ST_WR_B) || (state == ST_RD_B)) ? PH_B : PH_A;
    cnt_m1_c   = cnt - SELW'(1);
    first_rd_c = (state == ST_RD_A) ? (cnt == '0) : (cnt == ADDR_MAX);
    mis1_c     = rd_phase_c && (bus.rf_reg1 != exp_val(cnt, ph_c));
    mis2_c     = rd_phase_c && !first_rd_c && (bus.rf_reg2 != exp_val(cnt_m1_c, ph_c));
    mis_c      = mis1_c || mis2_c;
    fail_sel_c = mis1_c ? cnt : cnt_m1_c;
  end
`else
  always_comb begin
    rd_phase_c = (state == ST_RD_A) || (state == ST_RD_B);
    ph_c       = ((state == ST_WR_B) || (state == ST_RD_B)) ? PH_B : PH_A;
    mis1_c     = rd_phase_c && (bus.rf_reg1 != exp_val(cnt, ph_c));
    mis2_c     = 1'b0;
    mis_c      = mis1_c;
    fail_sel_c = cnt;
  end
`endif

  // Next-state and address-counter control.
  always_comb begin
    state_nxt    = state;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_load_val  = '0;
    ag_en        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_WR_A;
          ag_load   = 1'b1;
        end
      end
      ST_WR_A: begin
        ag_en = 1'b1;
        if (tc_c) begin
          state_nxt = ST_RD_A;
          ag_load   = 1'b1;
        end
      end
      ST_RD_A: begin
        ag_en = 1'b1;
        if (mis_c) begin
          state_nxt = ST_DONE;
        end else if (tc_c) begin
          state_nxt    = ST_WR_B;
          ag_load      = 1'b1;
          ag_load_down = 1'b1;
          ag_load_val  = ADDR_MAX;
        end
      end
      ST_WR_B: begin
        ag_en = 1'b1;
        if (tc_c) begin
          state_nxt    = ST_RD_B;
          ag_load      = 1'b1;
          ag_load_down = 1'b1;
          ag_load_val  = ADDR_MAX;
        end
      end
      ST_RD_B: begin
        ag_en = 1'b1;
        if (mis_c || tc_c) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next state and next address.
  always_comb begin
    wr_nxt   = (state_nxt == ST_WR_A) || (state_nxt == ST_WR_B);
    rd_nxt   = (state_nxt == ST_RD_A) || (state_nxt == ST_RD_B);
    ph_nxt   = ((state_nxt == ST_WR_B) || (state_nxt == ST_RD_B)) ? PH_B : PH_A;
    busy_nxt = wr_nxt || rd_nxt;
    done_nxt = (state_nxt == ST_DONE);
    we_nxt   = wr_nxt;
    wsel_nxt = wr_nxt ? cnt_nxt_c : '0;
    data_nxt = wr_nxt ? WIDTH'(bist_pattern(PAT_W'(PAT_SEED), PAT_W'(cnt_nxt_c), ph_nxt)) : '0;
    r1sel_nxt = rd_nxt ? cnt_nxt_c : '0;
`ifdef REGFILE_BIST_DUALPORT_EN
    r2sel_nxt = rd_nxt ? (cnt_nxt_c - SELW'(1)) : '0;
`else
    r2sel_nxt = '0;
`endif
    pass_nxt      = pass_q;
    fail_addr_nxt = fail_addr_q;
    fail_port_nxt = fail_port_q;
    if ((state == ST_IDLE) && bus.start) begin
      pass_nxt      = 1'b0;
      fail_addr_nxt = '0;
      fail_port_nxt = 1'b0;
    end
    if (mis_c) begin
      fail_addr_nxt = fail_sel_c;
      fail_port_nxt = !mis1_c;
    end
    if (done_nxt) begin
      pass_nxt = !mis_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_port_q <= 1'b0;
      we_q        <= 1'b0;
      wsel_q      <= '0;
      data_q      <= '0;
      r1sel_q     <= '0;
      r2sel_q     <= '0;
    end else begin
      state       <= state_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      pass_q      <= pass_nxt;
      fail_addr_q <= fail_addr_nxt;
      fail_port_q <= fail_port_nxt;
      we_q        <= we_nxt;
      wsel_q      <= wsel_nxt;
      data_q      <= data_nxt;
      r1sel_q     <= r1sel_nxt;
      r2sel_q     <= r2sel_nxt;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_port = fail_port_q;
  assign bus.rf_we     = we_q;
  assign bus.rf_wsel   = wsel_q;
  assign bus.rf_data   = data_q;
  assign bus.rf_r1sel  = r1sel_q;
  assign bus.rf_r2sel  = r2sel_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Scoreboard bench for regfile_bist with behavioural register-file models and fault injection.
module tb_regfile_bist;

  localparam int unsigned N  = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_bist_if #(.SELW(SW), .WIDTH(W)) bus ();
  regfile_bist_if #(.SELW(SW), .WIDTH(W)) bus0 ();

  regfile_bist #(.NREGS(N), .SELW(SW), .WIDTH(W), .PAT_SEED(32'hA5A5_A5A5), .R0_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));

  regfile_bist #(.NREGS(N), .SELW(SW), .WIDTH(W), .PAT_SEED(32'hA5A5_A5A5), .R0_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master));

  // Register-file models: r0 hardwired to zero, optional stuck bit and port-2 corruption.
  logic [W-1:0] rf_a [N];
  logic [W-1:0] rf_b [N];
  logic [W-1:0] v1, v2;
  bit stuck_en = 1'b0;
  bit p2_bad_sel = 1'b0;
  bit p2_bad_all = 1'b0;

  always_comb begin
    v1 = (bus.rf_r1sel == '0) ? '0 : rf_a[bus.rf_r1sel];
    if (stuck_en && (bus.rf_r1sel == SW'(7))) v1 = v1 | 32'h0000_0008;
    v2 = (bus.rf_r2sel == '0) ? '0 : rf_a[bus.rf_r2sel];
    if (stuck_en && (bus.rf_r2sel == SW'(7))) v2 = v2 | 32'h0000_0008;
    if (p2_bad_sel && (bus.rf_r2sel == SW'(12))) v2 = v2 ^ 32'h0000_0100;
    if (p2_bad_all) v2 = ~v2;
    bus.rf_reg1 = v1;
    bus.rf_reg2 = v2;
  end

  always_comb begin
    bus0.rf_reg1 = (bus0.rf_r1sel == '0) ? '0 : rf_b[bus0.rf_r1sel];
    bus0.rf_reg2 = (bus0.rf_r2sel == '0) ? '0 : rf_b[bus0.rf_r2sel];
  end

  always @(posedge clk) begin
    if (bus.rf_we) rf_a[bus.rf_wsel] <= bus.rf_data;
    if (bus0.rf_we) rf_b[bus0.rf_wsel] <= bus0.rf_data;
  end

  typedef struct {
    int   done_cyc;
    logic pass;
    int   fail_addr;
    logic fail_port;
    int   we_cycles;
  } exp_t;

  typedef struct {
    int         sel;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  exp_t exp0_q[$];
  wr_t  wr_q[$];
  exp_t me, me0;
  wr_t  mw;

  int cyc = 0;
  int s = 0;
  int s0 = 0;
  int vec_cnt = 0;
  int mis_cnt = 0;
  int we_cnt = 0;
  int run_target = 0;
  int runs_done = 0;
  int runs0_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat_a(input int i);
    return 32'hA5A5_A5A5 ^ 32'(i);
  endfunction

  // Scoreboard: writes and end-of-run results are popped as the DUT produces them.
  always @(negedge clk) begin
    if (bus.rf_we) begin
      we_cnt++;
      chk("write_expected", 64'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        mw = wr_q.pop_front();
        chk("wsel", bus.rf_wsel, mw.sel);
        chk("wdata", bus.rf_data, mw.data);
      end
    end
    if (bus.done) begin
      chk("done_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("done_cycle", cyc - s + 1, me.done_cyc);
        chk("busy_in_done", bus.busy, 0);
        chk("pass", bus.pass, me.pass);
        chk("fail_addr", bus.fail_addr, me.fail_addr);
        chk("fail_port", bus.fail_port, me.fail_port);
        chk("we_cycles", we_cnt, me.we_cycles);
      end
      wr_q.delete();
      runs_done++;
    end
  end

  always @(negedge clk) begin
    if (bus0.done) begin
      chk("r0_done_expected", 64'(exp0_q.size() > 0), 1);
      if (exp0_q.size() > 0) begin
        me0 = exp0_q.pop_front();
        chk("r0_done_cycle", cyc - s0 + 1, me0.done_cyc);
        chk("r0_pass", bus0.pass, me0.pass);
        chk("r0_fail_addr", bus0.fail_addr, me0.fail_addr);
        chk("r0_fail_port", bus0.fail_port, me0.fail_port);
      end
      runs0_done++;
    end
  end

  task automatic kick();
    wr_t t;
    @(negedge clk);
    wr_q.delete();
    for (int i = 0; i < int'(N); i++) begin
      t.sel = i; t.data = pat_a(i); wr_q.push_back(t);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      t.sel = i; t.data = ~pat_a(i); wr_q.push_back(t);
    end
    we_cnt = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    bus.start = 1'b0;
  endtask

  task automatic start_run(input int dc, input logic ps, input int fa, input logic fp, input int wes);
    exp_t e;
    e.done_cyc = dc; e.pass = ps; e.fail_addr = fa; e.fail_port = fp; e.we_cycles = wes;
    exp_q.push_back(e);
    run_target++;
    kick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (runs_done >= run_target) break;
    end
    chk("run_completes", 64'(runs_done >= run_target), 1);
    if (runs_done < run_target) begin
      exp_q.delete();
      wr_q.delete();
      runs_done = run_target;
    end
  endtask

  task automatic wait_cycle(input int c);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc - s + 1 >= c) break;
    end
    chk("reach_cycle", cyc - s + 1, c);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_fail_addr"}, bus.fail_addr, 0);
    chk({tag, "_fail_port"}, bus.fail_port, 0);
    chk({tag, "_we"}, bus.rf_we, 0);
    chk({tag, "_wsel"}, bus.rf_wsel, 0);
    chk({tag, "_data"}, bus.rf_data, 0);
    chk({tag, "_r1sel"}, bus.rf_r1sel, 0);
    chk({tag, "_r2sel"}, bus.rf_r2sel, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    bus.start  = 1'b0;
    bus0.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("r0_reset_busy", bus0.busy, 0);
    chk("r0_reset_we", bus0.rf_we, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Good register file; extra starts while busy and in DONE must be ignored.
    start_run(129, 1'b1, 0, 1'b0, 64);
    wait_cycle(10);
    pulse_start();
    wait_cycle(129);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("busy_after_done", bus.busy, 0);
    end
    wait_done(10);

    // Register 7 bit 3 stuck at 1.
    stuck_en = 1'b1;
    start_run(41, 1'b0, 7, 1'b0, 32);
    wait_done(200);
    stuck_en = 1'b0;

    // Reset mid-run in RD_A, then mid-run in WR_A.
    kick();
    wait_cycle(50);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_rd");
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    kick();
    wait_cycle(5);
    chk("we_before_reset", bus.rf_we, 1);
    reset = 1'b0;
    #1;
    chk("we_async_drop", bus.rf_we, 0);
    chk("busy_async_drop", bus.busy, 0);
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_run(129, 1'b1, 0, 1'b0, 64);
    wait_done(200);

`ifdef REGFILE_BIST_DUALPORT_EN
    p2_bad_sel = 1'b1;
    start_run(47, 1'b0, 12, 1'b1, 32);
    wait_done(200);
    p2_bad_sel = 1'b0;
`else
    p2_bad_all = 1'b1;
    start_run(129, 1'b1, 0, 1'b0, 64);
    wait_cycle(40);
    chk("r2sel_tied", bus.rf_r2sel, 0);
    wait_done(200);
    p2_bad_all = 1'b0;
`endif

    // R0_ZERO=0 against a register file whose r0 is hardwired.
    @(negedge clk);
    e0.done_cyc = 34; e0.pass = 1'b0; e0.fail_addr = 0; e0.fail_port = 1'b0; e0.we_cycles = 0;
    exp0_q.push_back(e0);
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    bus0.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (runs0_done >= 1) break;
    end
    chk("r0_run_completes", runs0_done, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test initiator for the 32-entry, two-read/one-write register file. On a `start` pulse, it takes the write and read-select ports, runs a four-phase march of writes and checked reads, and reports pass/fail with the first failing address. It sits beside the register file behind a port mux: it drives the register file during test and releases the ports when idle.

## Interface
- `NREGS`, 32: number of registers; must be a power of two.
- `SELW`, 5: select width, equal to log2(NREGS).
- `WIDTH`, 32: data width.
- `PAT_SEED`, 32'hA5A5_A5A5: pattern seed, truncated to WIDTH.
- `R0_ZERO`, 1: when 1, register 0 is hardwired, so its expected read value is 0.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a test run; sampled in IDLE only.
- `busy`  out  1  high while a test is running.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  result of the last run; held until the next start.
- `fail_addr`  out  SELW  first failing address; 0 if the run passed.
- `fail_port`  out  1  0 = read port 1 failed, 1 = read port 2 failed.
- `rf_wsel`  out  SELW  write select.
- `rf_data`  out  WIDTH  write data.
- `rf_we`  out  1  write enable.
- `rf_r1sel`, `rf_r2sel`  out  SELW  read selects.
- `rf_reg1`, `rf_reg2`  in  WIDTH  combinational read data from the register file.

## Operation
- Patterns:
  - A(i) = PAT_SEED ^ zero-extended i.
  - B(i) = ~A(i).
  - Expected value E(i) = 0 when i==0 and R0_ZERO=1; otherwise the pattern value.
- States: IDLE → WR_A → RD_A → WR_B → RD_B → DONE → IDLE.
- Phases:
  - WR_A: address counter runs 0..NREGS-1 ascending. `rf_we`=1, `rf_wsel`=addr, `rf_data`=A(addr).
  - RD_A: ascending. `rf_r1sel`=addr. Compares `rf_reg1` with E_A(addr) at each rising edge.
  - WR_B: descending, NREGS-1..0, writing B(addr).
  - RD_B: descending, comparing against E_B(addr).
- Counter wraps exactly at the phase boundary. The phase change and the counter reload happen on the same edge.
- Mismatch handling:
  - Latch `fail_addr` and `fail_port`, then go to DONE on the next edge, abandoning the remaining phases.
  - Only the first mismatch is recorded.
  - If port 1 and port 2 mismatch in the same cycle, report `fail_port`=0.
- `pass` = no mismatch recorded. It updates on the DONE-entry edge.
- `start` while busy, or while in DONE, is ignored.
- Arithmetic: addr-1 wraps modulo NREGS. All compares are full WIDTH.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_port`=0. All `rf_*` outputs are 0.
- `rf_we` drops to 0 asynchronously when `reset` asserts. Reset mid-run abandons the run without reporting.
- Full run with `start` sampled at edge E0:
  - `busy` is high from after E0.
  - Phases occupy cycles 1..N (WR_A), N+1..2N (RD_A), 2N+1..3N (WR_B), 3N+1..4N (RD_B).
  - `done` is high in cycle 4N+1 and `busy` is low in that cycle. The block is back in IDLE after edge 4N+1.
- A write issued at cycle k is read no earlier than cycle k+1, because the register file write is synchronous.
- `rf_we` is 0 outside the WR phases. In IDLE, all `rf_*` outputs are 0.

## Configuration
- `REGFILE_BIST_DUALPORT_EN` defined:
  - In RD phases, `rf_r2sel`=addr-1 (mod NREGS), and `rf_reg2` is checked against E(addr-1) of the current pattern.
  - The first RD cycle of each phase skips the port-2 check.
- Not defined: `rf_r2sel` is held at 0, `rf_reg2` is ignored, and `fail_port` is tied to 0.

## Structure
- Shared package `regfile_bist_pkg`:
  - state enum `bist_state_t`
  - `PAT_SEED` default
  - pattern function `bist_pattern(addr, phase)`
- One sub-module, `bist_addr_gen`: up/down address counter with load, enable, and terminal-count output. The FSM and compare logic stay in the top module.

## Test plan
- Good register file, start pulse:
  - `done` asserts in cycle 129 (N=32).
  - `pass`=1, `fail_addr`=0, `rf_we` high for exactly 64 cycles.
- Register 7 bit 3 stuck at 1:
  - RD_A fails at address 7 (A(7)=32'hA5A5_A5A2 has bit 3 = 0).
  - `done` in cycle 41, `pass`=0, `fail_addr`=7, `fail_port`=0.
- Register 0 hardwired to 0 with R0_ZERO=1: `pass`=1. With R0_ZERO=0: `fail_addr`=0, `pass`=0, `done` in cycle 34.
- Reset asserted in cycle 50:
  - All outputs return to 0 immediately and `rf_we`=0.
  - A new start after reset release gives a full 129-cycle run.
- `start` pulsed again in cycles 10 and 129: both are ignored, and `busy` stays low after cycle 129.
- With DUALPORT_EN, port 2 on the register file corrupted at address 12:
  - Failure reported at the first port-2 read of 12, on the RD_A cycle where port 1 reads address 13.
  - `fail_port`=1, `fail_addr`=12.
